// File: rtl/sb_cfg_pkg.sv
// sb_cfg_pkg: shared state type, default widths and the one-hot decode helper
// used by the switch-box configuration sequencer.
package sb_cfg_pkg;

  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } sb_cfg_state_e;

  // One-hot decode, one bit at a time: true when tile `pos` is the tile
  // selected by index `idx`.
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/sb_cfg_addr_decode.sv
// sb_cfg_addr_decode: maps a tile address plus write strobe onto a one-hot
// per-tile enable, and flags addresses beyond the populated tile range.
module sb_cfg_addr_decode
  import sb_cfg_pkg::*;
#(
  parameter int unsigned NUM_TILES = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic                 we_i,
  output logic [NUM_TILES-1:0] en_o,
  output logic                 oor_o
);

  // Address outside the tile array never selects any tile.
  assign oor_o = 32'(addr_i) >= NUM_TILES;

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_bit
    assign en_o[g] = we_i && onehot_bit(32'(addr_i), g);
  end

endmodule

// File: rtl/sb_config_sequencer.sv
// sb_config_sequencer: streams addressed config words onto the shared switch
// box config bus with a one-hot per-tile enable, counting words against a
// programmed load length. Optional word parity checking is built when
// SB_CFG_PARITY_EN is defined (adds cfg_parity / parity_err ports).
module sb_config_sequencer
  import sb_cfg_pkg::*;
#(
  parameter int unsigned NUM_TILES = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = SB_DATA_W,
  parameter int unsigned CNT_W     = SB_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [CNT_W-1:0]     cfg_count,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]    cfg_wdata,
`ifdef SB_CFG_PARITY_EN
  input  logic                 cfg_parity,
  output logic                 parity_err,
`endif
  output logic [DATA_W-1:0]    tile_config_data,
  output logic [NUM_TILES-1:0] tile_config_en,
  output logic                 busy,
  output logic                 cfg_done,
  output logic                 addr_err
);

  sb_cfg_state_e        state_q;
  logic [CNT_W:0]       remaining_q;
  logic [DATA_W-1:0]    data_q;
  logic [NUM_TILES-1:0] en_q;
  logic                 addr_err_q;
  logic [NUM_TILES-1:0] en_d;
  logic                 oor;
  logic                 accept;
  logic                 parity_ok;

  assign accept = cfg_valid && (state_q == LOAD);

`ifdef SB_CFG_PARITY_EN
  logic parity_err_q;
  // Even parity: the parity bit must equal the XOR of all data bits.
  assign parity_ok  = (cfg_parity == ^cfg_wdata);
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
`endif

  sb_cfg_addr_decode #(
    .NUM_TILES (NUM_TILES),
    .ADDR_W    (ADDR_W)
  ) u_decode (
    .addr_i (cfg_addr),
    .we_i   (accept && parity_ok),
    .en_o   (en_d),
    .oor_o  (oor)
  );

  // Handshake and status are decoded straight from the state register.
  assign cfg_ready        = (state_q == LOAD);
  assign busy             = (state_q == LOAD);
  assign cfg_done         = (state_q == DONE);
  assign tile_config_en   = en_q;
  assign tile_config_data = data_q;
  assign addr_err         = addr_err_q;

  // Load FSM, word counter, registered config bus and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      data_q       <= '0;
      en_q         <= '0;
      addr_err_q   <= 1'b0;
`ifdef SB_CFG_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      en_q <= en_d;
      if (|en_d) data_q <= cfg_wdata;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q     <= LOAD;
            remaining_q <= (cfg_count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cfg_count};
            addr_err_q  <= 1'b0;
`ifdef SB_CFG_PARITY_EN
            parity_err_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            remaining_q <= remaining_q - (CNT_W+1)'(1);
            if (oor) addr_err_q <= 1'b1;
`ifdef SB_CFG_PARITY_EN
            if (!parity_ok) parity_err_q <= 1'b1;
`endif
            if (remaining_q == (CNT_W+1)'(1)) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_config_sequencer.sv
// tb_sb_config_sequencer: drives two sequencers (16 and 12 tiles) with the
// same word stream and checks both against a word-level reference model every
// cycle, plus hand-computed spot checks at key points of each scenario.
module tb_sb_config_sequencer;

  localparam int NT [2] = '{16, 12};

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic [7:0]  cfg_count;
  logic        cfg_valid;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
`ifdef SB_CFG_PARITY_EN
  logic        cfg_parity;
  logic        par_flip;
  logic        perr16, perr12;
`endif

  logic        rdy16, busy16, done16, aerr16;
  logic [31:0] data16;
  logic [15:0] en16;
  logic        rdy12, busy12, done12, aerr12;
  logic [31:0] data12;
  logic [11:0] en12;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  sb_config_sequencer #(.NUM_TILES(16), .ADDR_W(4), .DATA_W(32), .CNT_W(8)) u16 (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_count(cfg_count),
    .cfg_valid(cfg_valid), .cfg_ready(rdy16), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef SB_CFG_PARITY_EN
    .cfg_parity(cfg_parity), .parity_err(perr16),
`endif
    .tile_config_data(data16), .tile_config_en(en16), .busy(busy16),
    .cfg_done(done16), .addr_err(aerr16)
  );

  sb_config_sequencer #(.NUM_TILES(12), .ADDR_W(4), .DATA_W(32), .CNT_W(8)) u12 (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_count(cfg_count),
    .cfg_valid(cfg_valid), .cfg_ready(rdy12), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef SB_CFG_PARITY_EN
    .cfg_parity(cfg_parity), .parity_err(perr12),
`endif
    .tile_config_data(data12), .tile_config_en(en12), .busy(busy12),
    .cfg_done(done12), .addr_err(aerr12)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ld;
  bit          m_dn;
  int          m_left;
  logic [15:0] m_en   [2];
  logic [31:0] m_data [2];
  bit          m_aerr [2];
  bit          m_perr [2];

  always @(posedge clk) begin
    bit acc, pok, last;
    if (reset) begin
      m_ld = 0; m_dn = 0; m_left = 0;
      for (int k = 0; k < 2; k++) begin
        m_en[k] = '0; m_data[k] = '0; m_aerr[k] = 0; m_perr[k] = 0;
      end
    end else begin
      acc = m_ld && cfg_valid;
`ifdef SB_CFG_PARITY_EN
      pok = (cfg_parity == ^cfg_wdata);
`else
      pok = 1'b1;
`endif
      for (int k = 0; k < 2; k++) begin
        m_en[k] = '0;
        if (acc) begin
          if (int'(cfg_addr) < NT[k]) begin
            if (pok) begin
              m_en[k]   = 16'd1 << cfg_addr;
              m_data[k] = cfg_wdata;
            end
          end else begin
            m_aerr[k] = 1;
          end
          if (!pok) m_perr[k] = 1;
        end
      end
      last = acc && (m_left == 1);
      if (!m_ld && !m_dn && cfg_start) begin
        m_ld   = 1;
        m_left = (cfg_count == 8'd0) ? 256 : int'(cfg_count);
        for (int k = 0; k < 2; k++) begin
          m_aerr[k] = 0; m_perr[k] = 0;
        end
      end else if (acc) begin
        m_left--;
        if (m_left == 0) m_ld = 0;
      end
      m_dn = last;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ready16", 32'(rdy16),  32'(m_ld));
      chk("busy16",  32'(busy16), 32'(m_ld));
      chk("done16",  32'(done16), 32'(m_dn));
      chk("en16",    32'(en16),   32'(m_en[0]));
      chk("data16",  data16,      m_data[0]);
      chk("aerr16",  32'(aerr16), 32'(m_aerr[0]));
      chk("ready12", 32'(rdy12),  32'(m_ld));
      chk("busy12",  32'(busy12), 32'(m_ld));
      chk("done12",  32'(done12), 32'(m_dn));
      chk("en12",    32'(en12),   32'(m_en[1]));
      chk("data12",  data12,      m_data[1]);
      chk("aerr12",  32'(aerr12), 32'(m_aerr[1]));
`ifdef SB_CFG_PARITY_EN
      chk("perr16",  32'(perr16), 32'(m_perr[0]));
      chk("perr12",  32'(perr12), 32'(m_perr[1]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Apply one input vector at a falling edge; return at the next falling
  // edge, where the registered effect of that vector is visible.
  task automatic drive(input logic st, input logic [7:0] cnt, input logic v,
                       input logic [3:0] a, input logic [31:0] d);
    cfg_start = st; cfg_count = cnt; cfg_valid = v; cfg_addr = a; cfg_wdata = d;
`ifdef SB_CFG_PARITY_EN
    cfg_parity = (^d) ^ par_flip;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cfg_start = 0; cfg_count = 0; cfg_valid = 0; cfg_addr = 0; cfg_wdata = 0;
`ifdef SB_CFG_PARITY_EN
    par_flip = 1'b0; cfg_parity = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_en",    32'(en16),   32'h0);
    chk("rst_busy",  32'(busy16), 32'h0);
    chk("rst_ready", 32'(rdy16),  32'h0);
    chk("rst_data",  data16,      32'h0);
    reset = 1'b0;

    // Basic load of three words, back to back.
    drive(1'b1, 8'd3, 1'b0, 4'd0, 32'h0);
    chk("basic_ready", 32'(rdy16), 32'h1);
    drive(1'b0, 8'd0, 1'b1, 4'd0,  32'h0000_0003);
    chk("basic_en0",   32'(en16), 32'h0001);
    chk("basic_d0",    data16,    32'h0000_0003);
    drive(1'b0, 8'd0, 1'b1, 4'd5,  32'h00FF_FF00);
    chk("basic_en5",   32'(en16), 32'h0020);
    chk("basic_d5",    data16,    32'h00FF_FF00);
    drive(1'b0, 8'd0, 1'b1, 4'd15, 32'hFFFF_FFFF);
    chk("basic_en15",  32'(en16), 32'h8000);
    chk("basic_done",  32'(done16), 32'h1);
    chk("basic_en15_12t", 32'(en12), 32'h0);
    chk("basic_aerr_12t", 32'(aerr12), 32'h1);
    idle();
    chk("basic_busy_after", 32'(busy16), 32'h0);
    chk("basic_data_hold",  data16, 32'hFFFF_FFFF);

    // Gapped valid: two words with a three-cycle gap.
    drive(1'b1, 8'd2, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd3, 32'hA5A5_0001);
    chk("gap_en3", 32'(en16), 32'h0008);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 1'b0, 4'd7, 32'hDEAD_BEEF);
      chk("gap_none", 32'(en16), 32'h0);
    end
    drive(1'b0, 8'd0, 1'b1, 4'd9, 32'h1234_5678);
    chk("gap_en9",  32'(en16),   32'h0200);
    chk("gap_done", 32'(done16), 32'h1);
    idle();

    // Bad address on the 12-tile instance, then clear on next start.
    drive(1'b1, 8'd2, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd13, 32'h1111_1111);
    chk("bad_en12",  32'(en12),   32'h0);
    chk("bad_aerr",  32'(aerr12), 32'h1);
    chk("bad_en16",  32'(en16),   32'h2000);
    drive(1'b0, 8'd0, 1'b1, 4'd2, 32'h2222_2222);
    chk("bad_en2",   32'(en12),   32'h004);
    chk("bad_done",  32'(done12), 32'h1);
    idle();
    chk("bad_sticky", 32'(aerr12), 32'h1);
    // Ignored valid in IDLE.
    drive(1'b0, 8'd0, 1'b1, 4'd1, 32'h3333_3333);
    chk("idle_ready", 32'(rdy16), 32'h0);
    chk("idle_en",    32'(en16),  32'h0);
    chk("idle_aerr",  32'(aerr12), 32'h1);
    drive(1'b1, 8'd2, 1'b0, 4'd0, 32'h0);
    chk("start_clr_aerr", 32'(aerr12), 32'h0);
    // Mid-load start with count 9 must not reload the count of 2.
    drive(1'b0, 8'd0, 1'b1, 4'd1, 32'h4444_4444);
    drive(1'b1, 8'd9, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd4, 32'h5555_5555);
    chk("midstart_en",   32'(en16),   32'h0010);
    chk("midstart_done", 32'(done16), 32'h1);
    idle();
    chk("midstart_idle", 32'(busy16), 32'h0);

    // Reset in the middle of a four-word load.
    drive(1'b1, 8'd4, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd6, 32'h6666_6666);
    drive(1'b0, 8'd0, 1'b1, 4'd7, 32'h7777_7777);
    chk("pre_rst_en", 32'(en16), 32'h0080);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("rst_mid_en",   32'(en16),   32'h0);
    chk("rst_mid_busy", 32'(busy16), 32'h0);
    chk("rst_mid_done", 32'(done16), 32'h0);
    idle();
    chk("rst_mid_nodone", 32'(done16), 32'h0);
    drive(1'b1, 8'd1, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd11, 32'hBBBB_0011);
    chk("post_rst_en",   32'(en16),   32'h0800);
    chk("post_rst_done", 32'(done16), 32'h1);
    idle();

    // Count 0 means 256 words.
    drive(1'b1, 8'd0, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 255; i++) begin
      drive(1'b0, 8'd0, 1'b1, 4'(i), 32'(i));
    end
    chk("wrap_busy_255", 32'(busy16), 32'h1);
    chk("wrap_nodone",   32'(done16), 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd15, 32'h0000_00FF);
    chk("wrap_done", 32'(done16), 32'h1);
    chk("wrap_en",   32'(en16),   32'h8000);
    idle();

`ifdef SB_CFG_PARITY_EN
    drive(1'b1, 8'd2, 1'b0, 4'd0, 32'h0);
    par_flip = 1'b1;
    drive(1'b0, 8'd0, 1'b1, 4'd3, 32'h0000_0007);
    par_flip = 1'b0;
    chk("par_en",  32'(en16),   32'h0);
    chk("par_err", 32'(perr16), 32'h1);
    drive(1'b0, 8'd0, 1'b1, 4'd3, 32'h0000_0007);
    chk("par_ok_en", 32'(en16),   32'h0008);
    chk("par_done",  32'(done16), 32'h1);
    idle();
    chk("par_sticky", 32'(perr16), 32'h1);
    drive(1'b1, 8'd1, 1'b0, 4'd0, 32'h0);
    chk("par_clr", 32'(perr16), 32'h0);
    drive(1'b0, 8'd0, 1'b1, 4'd0, 32'h0);
    idle();
`endif

    idle();
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
